// File: rtl/div_param.sv
// div_param: multi-cycle restoring divider, signed or unsigned, WIDTH-bit operands.
//
// One shift-subtract iteration per clock. An accepted start with a non-zero divisor
// delivers its result WIDTH edges later. A zero divisor finishes on the accepting edge.
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous active-high reset
//   start      operation request, sampled only in IDLE or DONE
//   signed_op  1 = two's-complement divide, 0 = unsigned (latched with start)
//   dividend   numerator (latched with start)
//   divisor    denominator (latched with start)
//   busy       high while iterating
//   done       one-cycle pulse, results valid
//   div_zero   latched divisor was zero
//   overflow   signed MIN / -1
//   quotient   registered quotient
//   remainder  registered remainder
module div_param #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             overflow,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q;
  logic [CntW-1:0]  count_q;
  logic [WIDTH-1:0] rem_q;      // partial remainder (always < divisor magnitude)
  logic [WIDTH-1:0] quo_q;      // dividend bits shift out of the top, quotient bits in at the bottom
  logic [WIDTH-1:0] dsr_q;      // divisor magnitude
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             ovf_q;

  logic             dvd_neg;
  logic             dsr_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;
  logic             is_ovf;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    dvd_neg = signed_op & dividend[WIDTH-1];
    dsr_neg = signed_op & divisor[WIDTH-1];
    // Negating MIN yields MIN, which is the correct unsigned magnitude 2^(WIDTH-1).
    dvd_mag = dvd_neg ? -dividend : dividend;
    dsr_mag = dsr_neg ? -divisor : divisor;
    is_ovf  = signed_op && (dividend == {1'b1, {(WIDTH - 1) {1'b0}}}) && (divisor == '1);

    // Restoring step on a WIDTH+1-bit partial remainder; borrow-out means restore.
    shifted  = {rem_q, quo_q[WIDTH-1]};
    diff     = shifted - {1'b0, dsr_q};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], q_bit};

    quo_fix  = neg_quo_q ? -quo_next : quo_next;
    rem_fix  = neg_rem_q ? -rem_next : rem_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ovf_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            div_zero <= 1'b0;
            overflow <= 1'b0;
            if (divisor == '0) begin
              div_zero  <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
              done      <= 1'b1;
              state_q   <= StDone;
            end else begin
              rem_q     <= '0;
              quo_q     <= dvd_mag;
              dsr_q     <= dsr_mag;
              neg_quo_q <= dvd_neg ^ dsr_neg;
              neg_rem_q <= dvd_neg;
              ovf_q     <= is_ovf;
              count_q   <= CntW'(WIDTH);
              busy      <= 1'b1;
              state_q   <= StRun;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          rem_q   <= rem_next;
          quo_q   <= quo_next;
          count_q <= count_q - CntW'(1);
          if (count_q == CntW'(1)) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            overflow  <= ovf_q;
            quotient  <= quo_fix;
            remainder <= rem_fix;
            state_q   <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_div_param.sv
// tb_div_param: directed, table-driven checks of div_param at WIDTH=32, plus hand
// sequences for start-during-run, back-to-back and reset-abort.
module tb_div_param;

  localparam int unsigned W = 32;

  logic         clock;
  logic         reset;
  logic         start;
  logic         signed_op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic         overflow;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int n_checks = 0;
  int n_pass   = 0;

  div_param #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .signed_op (signed_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .overflow  (overflow),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ovf;
    int           lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Called at #1 after a rising edge; start is seen on the next edge (edge k).
  // lat = edges after k until done is seen; bcnt = samples with busy high before done.
  task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int bcnt);
    signed_op = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat   = 0;
    bcnt  = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clock); #1;
      lat++;
    end
  endtask

  vec_t vecs[12];
  int   lat;
  int   bcnt;
  int   dcnt;

  initial begin
    vecs[0]  = '{1'b0, 32'd7,        32'd2,        32'd3,        32'd1,        1'b0, 1'b0, 32};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 32};
    vecs[2]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 1'b0, 32};
    vecs[3]  = '{1'b0, 32'h1234,     32'd0,        32'hFFFFFFFF, 32'h1234,     1'b1, 1'b0, 0};
    vecs[4]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 1'b1, 32};
    vecs[5]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 1'b0, 32};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 1'b0, 32};
    vecs[7]  = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0, 1'b0, 32};
    vecs[8]  = '{1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 32};
    vecs[9]  = '{1'b0, 32'hDEADBEEF, 32'h10,       32'h0DEADBEE, 32'hF,        1'b0, 1'b0, 32};
    vecs[10] = '{1'b1, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1'b0, 0};
    vecs[11] = '{1'b0, 32'd5,        32'd9,        32'd0,        32'd5,        1'b0, 1'b0, 32};

    reset     = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset div_zero", 64'(div_zero), 64'd0);
    chk("reset overflow", 64'(overflow), 64'd0);
    chk("reset quotient", 64'(quotient), 64'd0);
    chk("reset remainder", 64'(remainder), 64'd0);
    reset = 1'b0;

    // Table vectors; the first start follows reset release immediately.
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, bcnt);
      chk($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d busy cycles", i), 64'(bcnt), 64'(vecs[i].lat));
      chk($sformatf("v%0d quotient", i), 64'(quotient), 64'(vecs[i].q));
      chk($sformatf("v%0d remainder", i), 64'(remainder), 64'(vecs[i].r));
      chk($sformatf("v%0d div_zero", i), 64'(div_zero), 64'(vecs[i].dz));
      chk($sformatf("v%0d overflow", i), 64'(overflow), 64'(vecs[i].ovf));
      @(posedge clock); #1;
      chk($sformatf("v%0d done one cycle", i), 64'(done), 64'd0);
      chk($sformatf("v%0d results held q", i), 64'(quotient), 64'(vecs[i].q));
      chk($sformatf("v%0d busy after", i), 64'(busy), 64'd0);
    end

    // Start during RUN is ignored; original 7/2 result arrives on schedule.
    signed_op = 1'b0;
    dividend  = 32'd7;
    divisor   = 32'd2;
    start     = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 100) begin
      if (lat == 4) begin
        dividend  = 32'd100;
        divisor   = 32'd7;
        signed_op = 1'b1;
        start     = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      lat++;
    end
    start = 1'b0;
    chk("ignore latency", 64'(lat), 64'd32);
    chk("ignore quotient", 64'(quotient), 64'd3);
    chk("ignore remainder", 64'(remainder), 64'd1);

    // Back-to-back: start sampled in the DONE cycle.
    run_op(1'b0, 32'd100, 32'd7, lat, bcnt);
    chk("b2b first latency", 64'(lat), 64'd32);
    chk("b2b first quotient", 64'(quotient), 64'd14);
    run_op(1'b0, 32'd7, 32'd2, lat, bcnt);
    chk("b2b second latency", 64'(lat), 64'd32);
    chk("b2b second busy", 64'(bcnt), 64'd32);
    chk("b2b second quotient", 64'(quotient), 64'd3);
    chk("b2b second remainder", 64'(remainder), 64'd1);
    @(posedge clock); #1;

    // Reset at edge k+10 aborts with no done pulse.
    signed_op = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clock); #1;
    end
    chk("pre-abort busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort quotient", 64'(quotient), 64'd0);
    chk("abort remainder", 64'(remainder), 64'd0);
    chk("abort div_zero", 64'(div_zero), 64'd0);
    chk("abort overflow", 64'(overflow), 64'd0);
    dcnt = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done || busy) dcnt++;
    end
    chk("abort no done", 64'(dcnt), 64'd0);
    run_op(1'b0, 32'hFFFFFFFF, 32'd1, lat, bcnt);
    chk("post-abort latency", 64'(lat), 64'd32);
    chk("post-abort quotient", 64'(quotient), 64'hFFFFFFFF);
    chk("post-abort remainder", 64'(remainder), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_param.md
DIV_PARAM -- requirements
Module: div_param

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (SHALL support 4..64).
REQ-002 Single clock domain; reset is synchronous and active-high.
REQ-003 clock  input  1  rising-edge system clock, sole timing reference.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 start  input  1  request; SHALL be sampled only in IDLE or DONE.
REQ-006 signed_op  input  1  1 = two's-complement divide, 0 = unsigned divide; latched with start.
REQ-007 dividend  input  WIDTH  numerator; latched with start.
REQ-008 divisor  input  WIDTH  denominator; latched with start.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  single-cycle pulse marking valid results.
REQ-011 div_zero  output  1  latched divisor was zero; valid when done is high, held until next accepted start.
REQ-012 overflow  output  1  signed MIN / -1 case; valid when done is high, held until next accepted start.
REQ-013 quotient  output  WIDTH  registered quotient; held until next accepted start.
REQ-014 remainder  output  WIDTH  registered remainder; held until next accepted start.

Function
REQ-015 FSM states IDLE, RUN, DONE; all outputs driven from registers, no negedge logic.
REQ-016 Accepted start: start=1 at a rising edge while in IDLE or DONE; SHALL latch operands and signed_op, clear div_zero/overflow.
REQ-017 start in RUN SHALL be ignored, with no effect on state or results.
REQ-018 Accept with divisor=0 (edge k): IDLE/DONE -> DONE at edge k; div_zero=1, quotient=all ones, remainder=dividend, done high for the cycle after edge k.
REQ-019 Accept with divisor!=0 (edge k): -> RUN; load magnitudes (abs when signed_op=1 and MSB set) and set iteration counter=WIDTH.
REQ-020 RUN: one restoring shift-subtract iteration per rising edge, MSB-first, using a WIDTH+1-bit partial remainder; no early termination.
REQ-021 Final iteration at edge k+WIDTH SHALL register the sign-corrected results and move to DONE; done high for the cycle after edge k+WIDTH.
REQ-022 DONE -> IDLE at the next edge unless an accepted start occurs; done SHALL never be high for more than one cycle per operation.
REQ-023 Back-to-back: start accepted in DONE SHALL begin the next operation with no idle cycle.
REQ-024 Signed results: quotient truncates toward zero; negate quotient iff operand signs differ; remainder takes the dividend's sign.
REQ-025 Signed dividend=MIN, divisor=-1: overflow=1, quotient=MIN (wrapped), remainder=0, normal WIDTH-cycle latency.
REQ-026 Unsigned mode: no sign handling; overflow SHALL stay 0.
REQ-027 Invariant: for divisor!=0 and no overflow, quotient*divisor+remainder == dividend (mod 2^WIDTH), and |remainder| < |divisor|.

Reset
REQ-028 reset=1 at an edge SHALL force IDLE, busy=0, done=0, div_zero=0, overflow=0, quotient=0, remainder=0, counter=0.
REQ-029 Reset during RUN SHALL abort the operation with no done pulse; reset has priority over start.
REQ-030 After reset deassertion, the first start SHALL be accepted on the next edge.

Verification (WIDTH=32, start at edge k)
REQ-031 Unsigned 7/2 -> busy high for edges k..k+31, done after edge k+32, q=3, r=1, div_zero=0, overflow=0.
REQ-032 Signed -7/2 (0xFFFFFFF9/0x2) -> q=0xFFFFFFFD, r=0xFFFFFFFF; signed 7/-2 -> q=0xFFFFFFFD, r=1.
REQ-033 Divisor 0 with dividend 0x1234 -> done after edge k, div_zero=1, q=0xFFFFFFFF, r=0x1234, busy never high.
REQ-034 Signed 0x80000000/0xFFFFFFFF -> overflow=1, q=0x80000000, r=0; same operands unsigned -> q=0, r=0x80000000, overflow=0.
REQ-035 start pulsed at k+5 with new operands during RUN -> ignored, original result delivered; start in the DONE cycle -> second result after exactly 32 more edges.
REQ-036 reset at edge k+10 -> no done pulse, all outputs 0, IDLE; unsigned 0xFFFFFFFF/1 then -> q=0xFFFFFFFF, r=0.
